// File: rtl/stack_queue.sv
// stack_queue: single storage array usable as a LIFO (stack) or a FIFO (queue),
// with the mode chosen at run time. Simultaneous read/write is supported in
// both modes, overflow/underflow are reported as sticky flags, and the mode
// only changes while the buffer is empty and idle.
module stack_queue #(
   parameter int   DWIDTH       = 16,
   parameter int   AWIDTH       = 8,
   parameter int   ALMOST_FULL  = 2**AWIDTH-2,
   parameter int   ALMOST_EMPTY = 2,
   parameter logic INIT_MODE    = 1'b0
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              mode_i,
   output logic              mode_o,
   input  logic              wrreq_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_empty_o,
   output logic              almost_full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              ovf_o,
   output logic              udf_o
);

   localparam int              DEPTH   = 2**AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_U = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] AF_LVL  = (AWIDTH+1)'(ALMOST_FULL);
   localparam logic [AWIDTH:0] AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY);
   localparam logic [AWIDTH:0] ONE_U   = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);

   // Threshold sanity: catch impossible flag levels at elaboration time.
   generate
      if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
         $error("stack_queue: ALMOST_FULL must lie in 1..2**AWIDTH");
      end
      if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH) begin : g_bad_almost_empty
         $error("stack_queue: ALMOST_EMPTY must lie in 0..2**AWIDTH");
      end
   endgenerate

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH:0]   usedw;
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;

   logic              rd_acc;
   logic              wr_acc;
   logic              mode_sw;
   logic [AWIDTH-1:0] top_addr;
   logic [AWIDTH-1:0] rd_addr;
   logic [AWIDTH-1:0] wr_addr;
   logic [AWIDTH:0]   usedw_nxt;

   // Accept decisions, storage addresses and next occupancy for this cycle.
   always_comb begin
      rd_acc    = rdreq_i && (usedw != '0);
      // A full buffer still takes a write when a read frees a slot this cycle.
      wr_acc    = wrreq_i && ((usedw != DEPTH_U) || rd_acc);
      // Stack top; when full the low bits are zero and this wraps to DEPTH-1.
      top_addr  = usedw[AWIDTH-1:0] - ONE_A;
      rd_addr   = top_addr;
      wr_addr   = usedw[AWIDTH-1:0];
      if (mode_o) begin
         rd_addr = rd_ptr;
         wr_addr = wr_ptr;
      end else if (rd_acc) begin
         // Pop and push together: the incoming word replaces the old top.
         wr_addr = top_addr;
      end
      usedw_nxt = usedw;
      case ({wr_acc, rd_acc})
         2'b10:   usedw_nxt = usedw + ONE_U;
         2'b01:   usedw_nxt = usedw - ONE_U;
         default: usedw_nxt = usedw;
      endcase
      mode_sw   = (usedw == '0) && !wr_acc && (mode_i != mode_o);
   end

   // Storage array write port; contents are not cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!srst_i && wr_acc) begin
         mem[wr_addr] <= data_i;
      end
   end

   // Occupancy, pointers, mode, sticky error flags and registered read data.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         usedw  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         mode_o <= INIT_MODE;
         ovf_o  <= 1'b0;
         udf_o  <= 1'b0;
         q_o    <= '0;
      end else begin
         usedw <= usedw_nxt;
         if (wrreq_i && !wr_acc) begin
            ovf_o <= 1'b1;
         end
         if (rdreq_i && !rd_acc) begin
            udf_o <= 1'b1;
         end
         if (rd_acc) begin
            q_o <= mem[rd_addr];
         end
         if (mode_sw) begin
            mode_o <= mode_i;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (mode_o) begin
            if (wr_acc) begin
               wr_ptr <= wr_ptr + ONE_A;
            end
            if (rd_acc) begin
               rd_ptr <= rd_ptr + ONE_A;
            end
         end
      end
   end

   assign usedw_o        = usedw;
   assign empty_o        = (usedw == '0);
   assign full_o         = (usedw == DEPTH_U);
   assign almost_empty_o = (usedw < AE_LVL);
   assign almost_full_o  = (usedw >= AF_LVL);

endmodule

// File: tb/tb_stack_queue.sv
// Bench for stack_queue (AWIDTH=4, ALMOST_FULL=14, ALMOST_EMPTY=2, LIFO after
// reset). A queue-based reference model tracks contents, read data, mode and
// the sticky flags; each scenario task compares DUT outputs against it.
module tb_stack_queue;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          srst_i = 1'b1;
   logic          mode_i = 1'b0;
   logic          mode_o;
   logic          wrreq_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          rdreq_i = 1'b0;
   logic [DW-1:0] q_o;
   logic          empty_o, full_o, almost_empty_o, almost_full_o;
   logic [AW:0]   usedw_o;
   logic          ovf_o, udf_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_q = '0;
   logic          m_mode = 1'b0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic          mode_req = 1'b0;

   stack_queue #(
      .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL(14), .ALMOST_EMPTY(2), .INIT_MODE(1'b0)
   ) dut (
      .clk_i(clk), .srst_i(srst_i), .mode_i(mode_i), .mode_o(mode_o),
      .wrreq_i(wrreq_i), .data_i(data_i), .rdreq_i(rdreq_i), .q_o(q_o),
      .empty_o(empty_o), .full_o(full_o), .almost_empty_o(almost_empty_o),
      .almost_full_o(almost_full_o), .usedw_o(usedw_o), .ovf_o(ovf_o), .udf_o(udf_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One clock of traffic; the model applies the accept rules at a queue level.
   task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
      int   n;
      logic rd_ok, wr_ok;
      wrreq_i = wr; rdreq_i = rd; data_i = d; mode_i = mode_req;
      n     = mq.size();
      rd_ok = rd && (n > 0);
      wr_ok = wr && ((n < DEPTH) || rd_ok);
      @(posedge clk);
      if (rd && !rd_ok) m_udf = 1'b1;
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_q = m_mode ? mq.pop_front() : mq.pop_back();
      if (wr_ok) mq.push_back(d);
      if ((n == 0) && !wr_ok) m_mode = mode_req;
      #1;
      wrreq_i = 1'b0; rdreq_i = 1'b0;
   endtask

   task automatic do_reset();
      srst_i = 1'b1; wrreq_i = 1'b0; rdreq_i = 1'b0;
      @(posedge clk);
      mq.delete(); m_q = '0; m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      #1;
      srst_i = 1'b0;
   endtask

   task automatic test_reset();
      mode_req = 1'b0;
      do_reset();
      checks++; if (usedw_o !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d expected 0", usedw_o); end
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
      checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty_o); end
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_o); end
      checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full_o); end
      checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", ovf_o, udf_o); end
      checks++; if (q_o !== 16'h0) begin errors++; $display("FAIL reset_q: got %h expected 0000", q_o); end
      checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b expected 0", mode_o); end
   endtask

   task automatic test_lifo_basic();
      logic [DW-1:0] words[DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         words[i] = DW'($urandom);
         cycle(1'b1, 1'b0, words[i]);
         if (i == 12) begin
            checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL lifo_af_13: got %b expected 0", almost_full_o); end
         end
         if (i == 13) begin
            checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL lifo_af_14: got %b expected 1", almost_full_o); end
            checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL lifo_full_14: got %b expected 0", full_o); end
         end
      end
      checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL lifo_full_16: got %b expected 1", full_o); end
      checks++; if (usedw_o !== 5'd16) begin errors++; $display("FAIL lifo_usedw_16: got %0d expected 16", usedw_o); end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, '0);
         checks++;
         if (q_o !== words[DEPTH-1-i]) begin errors++; $display("FAIL lifo_pop_%0d: got %h expected %h", i, q_o, words[DEPTH-1-i]); end
      end
      checks++; if (empty_o !== 1'b1 || usedw_o !== 5'd0) begin errors++; $display("FAIL lifo_drained: got empty=%b usedw=%0d expected 1 0", empty_o, usedw_o); end
   endtask

   task automatic test_fifo_wrap();
      logic [DW-1:0] words[DEPTH];
      mode_req = 1'b1;
      cycle(1'b0, 1'b0, '0);
      checks++; if (mode_o !== 1'b1) begin errors++; $display("FAIL fifo_mode: got %b expected 1", mode_o); end
      for (int pass = 0; pass < 2; pass++) begin
         int cnt;
         cnt = (pass == 0) ? 10 : 16;
         for (int i = 0; i < cnt; i++) begin
            words[i] = DW'($urandom);
            cycle(1'b1, 1'b0, words[i]);
         end
         checks++; if (usedw_o !== 5'(cnt)) begin errors++; $display("FAIL fifo_fill_%0d: got %0d expected %0d", pass, usedw_o, cnt); end
         for (int i = 0; i < cnt; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if (q_o !== words[i]) begin errors++; $display("FAIL fifo_order_%0d_%0d: got %h expected %h", pass, i, q_o, words[i]); end
         end
         checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin errors++; $display("FAIL fifo_flags_%0d: got ovf=%b udf=%b expected 0 0", pass, ovf_o, udf_o); end
      end
   endtask

   task automatic test_ovf_udf();
      logic [DW-1:0] held;
      mode_req = 1'b0;
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom));
      cycle(1'b1, 1'b0, 16'hDEAD);
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_o); end
      checks++; if (usedw_o !== 5'd16) begin errors++; $display("FAIL ovf_usedw: got %0d expected 16", usedw_o); end
      checks++; if (udf_o !== 1'b0) begin errors++; $display("FAIL ovf_no_udf: got %b expected 0", udf_o); end
      cycle(1'b0, 1'b1, '0);
      checks++; if (q_o !== m_q) begin errors++; $display("FAIL ovf_top_kept: got %h expected %h", q_o, m_q); end
      while (mq.size() > 0) cycle(1'b0, 1'b1, '0);
      mode_req = 1'b1;
      cycle(1'b0, 1'b0, '0);
      held = q_o;
      cycle(1'b0, 1'b1, '0);
      checks++; if (udf_o !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", udf_o); end
      checks++; if (q_o !== held || q_o !== m_q) begin errors++; $display("FAIL udf_q_hold: got %h expected %h", q_o, m_q); end
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'($urandom));
      checks++; if (ovf_o !== 1'b1 || udf_o !== 1'b1) begin errors++; $display("FAIL flags_sticky: got ovf=%b udf=%b expected 1 1", ovf_o, udf_o); end
      mode_req = 1'b0;
      do_reset();
      checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin errors++; $display("FAIL flags_cleared: got ovf=%b udf=%b expected 0 0", ovf_o, udf_o); end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] a, b, c, first;
      a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
      cycle(1'b1, 1'b0, a);
      cycle(1'b1, 1'b0, b);
      cycle(1'b1, 1'b1, c);
      checks++; if (q_o !== b) begin errors++; $display("FAIL lifo_rw_q: got %h expected %h", q_o, b); end
      checks++; if (usedw_o !== 5'd2) begin errors++; $display("FAIL lifo_rw_usedw: got %0d expected 2", usedw_o); end
      cycle(1'b0, 1'b1, '0);
      checks++; if (q_o !== c) begin errors++; $display("FAIL lifo_rw_next: got %h expected %h", q_o, c); end
      cycle(1'b0, 1'b1, '0);
      checks++; if (q_o !== a) begin errors++; $display("FAIL lifo_rw_bottom: got %h expected %h", q_o, a); end
      cycle(1'b1, 1'b1, c);
      checks++; if (udf_o !== 1'b1 || usedw_o !== 5'd1) begin errors++; $display("FAIL lifo_rw_empty: got udf=%b usedw=%0d expected 1 1", udf_o, usedw_o); end
      cycle(1'b0, 1'b1, '0);
      checks++; if (q_o !== c) begin errors++; $display("FAIL lifo_rw_empty_data: got %h expected %h", q_o, c); end
      mode_req = 1'b1;
      do_reset();
      cycle(1'b0, 1'b0, '0);
      first = DW'($urandom);
      cycle(1'b1, 1'b0, first);
      for (int i = 1; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom));
      cycle(1'b1, 1'b1, DW'($urandom));
      checks++; if (q_o !== first) begin errors++; $display("FAIL fifo_rw_full_q: got %h expected %h", q_o, first); end
      checks++; if (usedw_o !== 5'd16 || full_o !== 1'b1) begin errors++; $display("FAIL fifo_rw_full_usedw: got %0d expected 16", usedw_o); end
      checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL fifo_rw_full_ovf: got %b expected 0", ovf_o); end
      while (mq.size() > 0) begin
         cycle(1'b0, 1'b1, '0);
         checks++; if (q_o !== m_q) begin errors++; $display("FAIL fifo_rw_drain: got %h expected %h", q_o, m_q); end
      end
   endtask

   task automatic test_mode_guard();
      logic [DW-1:0] words[3];
      mode_req = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         words[i] = DW'($urandom);
         cycle(1'b1, 1'b0, words[i]);
      end
      for (int i = 0; i < 4; i++) begin
         mode_req = ~mode_req;
         cycle(1'b0, 1'b0, '0);
         checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_hold_%0d: got %b expected 0", i, mode_o); end
      end
      mode_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, '0);
         checks++; if (q_o !== words[2-i]) begin errors++; $display("FAIL mode_drain_%0d: got %h expected %h", i, q_o, words[2-i]); end
      end
      checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_before_switch: got %b expected 0", mode_o); end
      cycle(1'b0, 1'b0, '0);
      checks++; if (mode_o !== 1'b1) begin errors++; $display("FAIL mode_switch: got %b expected 1", mode_o); end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'($urandom));
      cycle(1'b0, 1'b1, '0);
      wrreq_i = 1'b1; rdreq_i = 1'b1; data_i = DW'($urandom); srst_i = 1'b1;
      @(posedge clk);
      mq.delete(); m_q = '0; m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      #1;
      srst_i = 1'b0; wrreq_i = 1'b0; rdreq_i = 1'b0;
      checks++; if (usedw_o !== 5'd0 || empty_o !== 1'b1) begin errors++; $display("FAIL midreset_usedw: got %0d empty=%b expected 0 1", usedw_o, empty_o); end
      checks++; if (q_o !== 16'h0) begin errors++; $display("FAIL midreset_q: got %h expected 0000", q_o); end
      checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL midreset_mode: got %b expected 0", mode_o); end
      mode_req = 1'b0;
   endtask

   task automatic test_random();
      int wr_bias;
      do_reset();
      wr_bias = 60;
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) wr_bias = ((i / 60) % 2 == 0) ? 75 : 25;
         if ($urandom_range(15) == 0) mode_req = ~mode_req;
         cycle($urandom_range(99) < wr_bias, $urandom_range(99) >= wr_bias - 10, DW'($urandom));
         checks++; if (usedw_o !== 5'(mq.size())) begin errors++; $display("FAIL rnd_usedw_%0d: got %0d expected %0d", i, usedw_o, mq.size()); end
         checks++; if (q_o !== m_q) begin errors++; $display("FAIL rnd_q_%0d: got %h expected %h", i, q_o, m_q); end
         checks++; if (mode_o !== m_mode) begin errors++; $display("FAIL rnd_mode_%0d: got %b expected %b", i, mode_o, m_mode); end
         checks++; if (ovf_o !== m_ovf || udf_o !== m_udf) begin errors++; $display("FAIL rnd_flags_%0d: got ovf=%b udf=%b expected %b %b", i, ovf_o, udf_o, m_ovf, m_udf); end
         checks++;
         if (empty_o !== (mq.size() == 0) || full_o !== (mq.size() == DEPTH) ||
             almost_empty_o !== (mq.size() < 2) || almost_full_o !== (mq.size() >= 14)) begin
            errors++;
            $display("FAIL rnd_level_%0d: got e=%b f=%b ae=%b af=%b for %0d words", i, empty_o, full_o, almost_empty_o, almost_full_o, mq.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_lifo_basic();
      test_fifo_wrap();
      test_ovf_udf();
      test_simultaneous();
      test_mode_guard();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
